// File: rtl/mcu51_pkg.sv
// Shared MCU51 fetch definitions: widths, reset vector, FSM states.
// Queue entries pair each byte with the address it came from.
package mcu51_pkg;

  localparam int PC_W   = 16;
  localparam int BYTE_W = 8;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [BYTE_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/ins_fetch_unit_if.sv
// Program-memory and decoder-side signals of the fetch stage.
// master = fetch unit, slave = memory / decoder / branch side.
interface ins_fetch_unit_if;
  import mcu51_pkg::*;

  logic              EA;
  logic              rom_req;
  logic [PC_W-1:0]   rom_addr;
  logic              rom_rvalid;
  logic [BYTE_W-1:0] rom_rdata;
  logic              ALE;
  logic              PSEN;
  logic              ins_valid;
  logic              ins_ready;
  logic [BYTE_W-1:0] ins_byte;
  logic [PC_W-1:0]   ins_pc;
  logic              pc_load;
  logic [PC_W-1:0]   pc_target;

  modport master (
    input  EA, rom_rvalid, rom_rdata,
    input  ins_ready, pc_load, pc_target,
    output rom_req, rom_addr, ALE, PSEN,
    output ins_valid, ins_byte, ins_pc
  );

  modport slave (
    output EA, rom_rvalid, rom_rdata,
    output ins_ready, pc_load, pc_target,
    input  rom_req, rom_addr, ALE, PSEN,
    input  ins_valid, ins_byte, ins_pc
  );

endinterface

// File: rtl/ins_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, byte} entries with synchronous clear.
// Head entry resets to {RST_PC, 0} so decoder outputs start defined.
module fetch_queue
  import mcu51_pkg::*;
#(
  parameter int              QDEPTH = 4,
  parameter logic [PC_W-1:0] RST_PC = RESET_VECTOR_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  fetch_entry_t    mem_q [QDEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '{pc: RST_PC, data: '0};
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(QDEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding ROM reads, prefetch queue.
// Optional same-cycle bypass to the decoder: define FETCH_BYPASS_EN.
module ins_fetch_unit
  import mcu51_pkg::*;
#(
  parameter int              QDEPTH       = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  ins_fetch_unit_if.master    bus
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int NW = CW + 1;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic             ext_q, ext_d;

  logic             take;
  logic             keep;
  logic             byp;
  logic             valid;
  logic             pop;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [CW-1:0]    q_count;
  logic [NW-1:0]    cnt_nx;
  fetch_entry_t     q_head;
  fetch_entry_t     q_wdata;

  assign q_wdata = '{pc: req_pc_q, data: bus.rom_rdata};

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .RST_PC (RESET_VECTOR)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .clear (bus.pc_load),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    ext_d      = ext_q;

    take = (state_q == WAIT) && bus.rom_rvalid;
    keep = take && !discard_q && !bus.pc_load;
`ifdef FETCH_BYPASS_EN
    byp  = keep && q_empty;
`else
    byp  = 1'b0;
`endif
    valid  = !q_empty || byp;
    pop    = valid && bus.ins_ready && !bus.pc_load;
    q_pop  = pop && !q_empty;
    q_push = keep && !(byp && pop);
    cnt_nx = bus.pc_load ? '0 :
             ({1'b0, q_count} + NW'(q_push) - NW'(q_pop));

    unique case (state_q)
      IDLE: begin
        if (bus.pc_load || !q_full) state_d = REQ;
      end
      REQ: begin
        state_d    = WAIT;
        fetch_pc_d = fetch_pc_q + 1'b1;
        req_pc_d   = fetch_pc_q;
        ext_d      = !bus.EA;
      end
      WAIT: begin
        if (take) begin
          discard_d = 1'b0;
          state_d   = (cnt_nx < NW'(QDEPTH)) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins; a response still in flight must not reach the queue
    if (bus.pc_load) begin
      fetch_pc_d = bus.pc_target;
      if ((state_q == REQ) || ((state_q == WAIT) && !take)) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VECTOR;
      req_pc_q   <= RESET_VECTOR;
      discard_q  <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      ext_q      <= ext_d;
    end
  end

  assign bus.rom_req   = (state_q == REQ);
  assign bus.rom_addr  = fetch_pc_q;
  assign bus.ALE       = (state_q == REQ) && !bus.EA;
  assign bus.PSEN      = !(((state_q == REQ) && !bus.EA) ||
                           ((state_q == WAIT) && ext_q));
  assign bus.ins_valid = valid;
  assign bus.ins_byte  = byp ? bus.rom_rdata : q_head.data;
  assign bus.ins_pc    = byp ? req_pc_q : q_head.pc;

endmodule
